// File: rtl/uart_rx_deserializer_pkg.sv
// Shared line configuration for the UART receive path.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: system clock frequency and line baud rate, common to the bus
// interface and every receiver instantiated inside it.
package uart_rx_deserializer_pkg;

   localparam int unsigned CFG_SYS_FREQ_HZ    = 12_000_000;
   localparam int unsigned CFG_UART_BAUD_RATE = 115_200;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts sys_clk cycles and emits a tick at each UART sample point.
// Latency: tick is combinational from the count; first tick HALF_BIT or CLKS_PER_BIT cycles after restart.
// Backpressure: none; free-running while not restarted.
// Ports: sys_clk/rst (sync, active-high), restart clears the count, half selects
//        the half-bit period, tick marks a sample point (count restarts at 0 there).
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned HALF_BIT     = 52
)(
   input  logic sys_clk,
   input  logic rst,
   input  logic restart,
   input  logic half,
   output logic tick
);

   // Just wide enough to hold CLKS_PER_BIT-1.
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LIM_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LIM_HALF = CW'(HALF_BIT - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == (half ? LIM_HALF : LIM_FULL));

   always_ff @(posedge sys_clk) begin
      if (rst || restart || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: deserializes an already-synchronized rx line into NUM_DATA_BITS words, LSB first.
// Latency: new_data_ready/frame_error pulse one cycle after the stop-bit sample point.
// Backpressure: none; words are overwritten by the next frame, pulses are single-cycle.
// Ports: sys_clk, rst (sync, active-high), rx_in (idle high),
//        recv_data (last good word), new_data_ready / frame_error (1-cycle pulses), busy.
module uart_rx_deserializer
   import uart_rx_deserializer_pkg::*;
#(
   parameter int unsigned SYS_FREQ_HZ    = CFG_SYS_FREQ_HZ,
   parameter int unsigned UART_BAUD_RATE = CFG_UART_BAUD_RATE,
   parameter int unsigned NUM_DATA_BITS  = 8
)(
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic                     rx_in,
   output logic [NUM_DATA_BITS-1:0] recv_data,
   output logic                     new_data_ready,
   output logic                     frame_error,
   output logic                     busy
);

   localparam int unsigned CLKS_PER_BIT = SYS_FREQ_HZ / UART_BAUD_RATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned BW           = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;

   generate
      if (CLKS_PER_BIT < 4) begin : g_cfg_check
         $error("uart_rx_deserializer: CLKS_PER_BIT (%0d) must be at least 4", CLKS_PER_BIT);
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_RECOVER
   } state_t;

   state_t                   state_q, state_d;
   logic [BW-1:0]            bit_cnt_q;
   logic [NUM_DATA_BITS-1:0] shift_q;

   logic timer_restart;
   logic timer_half;
   logic sample_tick;
   logic bit_clr;
   logic shift_en;
   logic deliver;
   logic ferr;

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .HALF_BIT     (HALF_BIT)
   ) u_bit_timer (
      .sys_clk (sys_clk),
      .rst     (rst),
      .restart (timer_restart),
      .half    (timer_half),
      .tick    (sample_tick)
   );

   always_comb begin
      state_d       = state_q;
      timer_restart = 1'b0;
      timer_half    = 1'b0;
      bit_clr       = 1'b0;
      shift_en      = 1'b0;
      deliver       = 1'b0;
      ferr          = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Timer is held at 0 so the cycle the start edge is seen is t0.
            timer_restart = 1'b1;
            if (!rx_in) begin
               state_d = S_START;
               bit_clr = 1'b1;
            end
         end
         S_START: begin
            timer_half = 1'b1;
            if (sample_tick) begin
               state_d = rx_in ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (sample_tick) begin
               shift_en = 1'b1;
               if (bit_cnt_q == BW'(NUM_DATA_BITS - 1)) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (sample_tick) begin
               if (rx_in) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_d = S_RECOVER;
               end
            end
         end
         S_RECOVER: begin
            // Wait out a break so it reports only one frame error.
            if (rx_in) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         recv_data      <= '0;
         new_data_ready <= 1'b0;
         frame_error    <= 1'b0;
      end else begin
         state_q        <= state_d;
         new_data_ready <= deliver;
         frame_error    <= ferr;
         if (bit_clr) begin
            bit_cnt_q <= '0;
         end else if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + BW'(1);
         end
         if (shift_en) begin
            shift_q <= {rx_in, shift_q[NUM_DATA_BITS-1:1]};
         end
         if (deliver) begin
            recv_data <= shift_q;
         end
      end
   end

   // The delivery cycle counts as busy so a consumer never sees idle before the word lands.
   assign busy = (state_q != S_IDLE) || new_data_ready;

endmodule
